// File: rtl/cb_sampler_pkg.sv
// Shared types and constants for the cb_sampler bus sampler.
// The record layout is {data, ts}, with data in the upper bits.
package cb_sampler_pkg;

   localparam int MAX_SKEW  = 7;
   localparam int DROP_W    = 8;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_TS_W  = 16;

   // Record layout at the default widths. The top re-declares it with its own widths.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic [DEF_TS_W-1:0]  ts;
   } cb_rec_t;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/cb_sampler_fifo.sv
// Synchronous record FIFO with a combinational head.
// A push while full is accepted only when a pop happens in the same cycle.
module cb_sampler_fifo #(
   parameter int REC_W = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [REC_W-1:0] push_data,
   input  logic             pop,
   output logic [REC_W-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   // The extra pointer bit tells full apart from empty when the indices are equal.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/cb_sampler.sv
// Change-based bus sampler. It sends din through a skew pipe, then records {value, timestamp} on each change.
// Optional feature: define CB_SAMPLER_DROP_CNT_EN to add the saturating drop_cnt output.
module cb_sampler
   import cb_sampler_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SKEW  = 2,
   parameter int DEPTH = 4,
   parameter int TS_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  din,
   input  logic              en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [TS_W-1:0]   out_ts,
`ifdef CB_SAMPLER_DROP_CNT_EN
   output logic [DROP_W-1:0] drop_cnt,
`endif
   output logic              full
);

   if (SKEW < 0 || SKEW > MAX_SKEW) begin : g_bad_skew
      $fatal(1, "cb_sampler: SKEW must be within 0..%0d", MAX_SKEW);
   end
   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $fatal(1, "cb_sampler: DEPTH must be a power of two and at least 2");
   end

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [TS_W-1:0]  ts;
   } rec_t;

   logic [WIDTH-1:0] stage_out;
   logic [WIDTH-1:0] samp;
   logic [TS_W-1:0]  ts;
   logic             first_flag;
   logic             push;
   logic             fifo_empty;
   rec_t             push_rec, pop_rec;

   if (SKEW == 0) begin : g_noskew
      assign stage_out = din;
   end else begin : g_skew
      logic [SKEW-1:0][WIDTH-1:0] skew_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            skew_q <= '0;
         end else begin
            skew_q[0] <= din;
            for (int i = 1; i < SKEW; i++)
               skew_q[i] <= skew_q[i-1];
         end
      end
      assign stage_out = skew_q[SKEW-1];
   end

   // The push decision is made on the edge that loads samp. The record therefore carries the ts
   // value of the cycle in which samp first shows the new value.
   assign push = en && ((stage_out != samp) || first_flag);

   always_comb begin
      push_rec      = '0;
      push_rec.data = stage_out;
      push_rec.ts   = ts + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         samp       <= '0;
         ts         <= '0;
         first_flag <= 1'b1;
      end else begin
         samp <= stage_out;
         ts   <= ts + 1'b1;
         if (push)
            first_flag <= 1'b0;
      end
   end

   cb_sampler_fifo #(
      .REC_W ($bits(rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_rec),
      .pop       (out_ready),
      .pop_data  (pop_rec),
      .full      (full),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = pop_rec.data;
   assign out_ts    = pop_rec.ts;

`ifdef CB_SAMPLER_DROP_CNT_EN
   logic drop;
   assign drop = push && full && !(out_ready && out_valid);

   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop && drop_cnt != {DROP_W{1'b1}})
         drop_cnt <= drop_cnt + 1'b1;
   end
`else
`endif

endmodule

// File: tb/tb_cb_sampler.sv
// Directed bench for cb_sampler at its default parameters (WIDTH 8, SKEW 2, DEPTH 4, TS_W 16).
// Cycle k means the interval after the k-th rising edge that follows reset release, where ts equals k.
module tb_cb_sampler;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        en;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [15:0] out_ts;
   logic        full;
`ifdef CB_SAMPLER_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cb_sampler dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .en        (en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ts    (out_ts),
`ifdef CB_SAMPLER_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .full      (full)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rec(input string tag, input logic [7:0] d, input logic [15:0] t);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".ts"},    32'(out_ts),    32'(t));
   endtask

   task automatic chk_drop(input string tag, input logic [7:0] exp);
`ifdef CB_SAMPLER_DROP_CNT_EN
      chk(tag, 32'(drop_cnt), 32'(exp));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; din = 8'h00; out_ready = 1'b0;
      step();
      step();
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.full",  32'(full),      0);
      chk("rst.data",  32'(out_data),  0);
      chk("rst.ts",    32'(out_ts),    0);
      chk_drop("rst.drop", 8'd0);

      // Latency: the forced first record, then the change applied in cycle 10
      rst = 1'b0;
      step();
      chk_rec("lat.first", 8'h00, 16'd1);
      repeat (9) step();
      din = 8'h01;
      repeat (3) step();
      chk_rec("lat.hold", 8'h00, 16'd1);
      out_ready = 1'b1;
      step();
      chk_rec("lat.second", 8'h01, 16'd13);
      step();
      chk("lat.empty", 32'(out_valid), 0);

      // Stepped bus with a consumer that is always ready
      din = 8'h00;
      do_reset();
      out_ready = 1'b1;
      step();
      chk_rec("step.first", 8'h00, 16'd1);
      step();
      chk("step.drained", 32'(out_valid), 0);
      for (int i = 0; i < 11; i++) begin
         if (i < 8) din = 8'(1 << i);
         if (i >= 3) chk_rec($sformatf("step.rec%0d", i - 3), 8'(1 << (i - 3)), 16'(2 + i));
         step();
      end
      chk("step.empty", 32'(out_valid), 0);
      chk_drop("step.drop", 8'd0);

      // Overflow: six changes with no consumer
      din = 8'h00;
      out_ready = 1'b0;
      do_reset();
      out_ready = 1'b1;
      step();
      chk_rec("ovf.first", 8'h00, 16'd1);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         din = 8'(8'h10 + i);
         if (i == 5) chk("ovf.notfull3", 32'(full), 0);
         step();
      end
      chk("ovf.full4", 32'(full), 1);
      repeat (3) step();
      chk("ovf.full", 32'(full), 1);
      chk_rec("ovf.head", 8'h10, 16'd5);
      chk_drop("ovf.drop", 8'd2);

      // Push and pop on the same edge while full
      din = 8'h20;
      step();
      step();
      out_ready = 1'b1;
      step();
      chk("pp.full", 32'(full), 1);
      chk_rec("pp.r0", 8'h11, 16'd6);
      step();
      chk_rec("pp.r1", 8'h12, 16'd7);
      step();
      chk_rec("pp.r2", 8'h13, 16'd8);
      step();
      chk_rec("pp.tail", 8'h20, 16'd14);
      step();
      chk("pp.empty", 32'(out_valid), 0);
      chk_drop("pp.drop", 8'd2);

      // Enable gating: a change made while en is low is never reported
      din = 8'h00;
      do_reset();
      step();
      chk_rec("en.first", 8'h00, 16'd1);
      step();
      en = 1'b0;
      din = 8'h55;
      repeat (6) step();
      en = 1'b1;
      repeat (5) step();
      chk("en.no55", 32'(out_valid), 0);
      din = 8'h56;
      repeat (3) step();
      chk_rec("en.56", 8'h56, 16'd16);

      // Reset while records are queued
      step();
      out_ready = 1'b0;
      din = 8'h61;
      step();
      din = 8'h62;
      step();
      din = 8'h63;
      repeat (3) step();
      chk_rec("mrst.queued", 8'h61, 16'd20);
      rst = 1'b1;
      step();
      chk("mrst.valid", 32'(out_valid), 0);
      chk("mrst.full",  32'(full),      0);
      chk("mrst.data",  32'(out_data),  0);
      chk("mrst.ts",    32'(out_ts),    0);
      chk_drop("mrst.drop", 8'd0);
      rst = 1'b0;
      step();
      chk_rec("mrst.forced", 8'h00, 16'd1);
      step();
      step();
      out_ready = 1'b1;
      step();
      chk_rec("mrst.next", 8'h63, 16'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
